// File: rtl/light_pkg.sv
// Shared selector types for the light-line sequencer and the line managers.
// Optional feature macro used by dependent files: LIGHT_SEQ_DOWN_EN.
package light_pkg;

  localparam int SEL_W = 6;

  typedef logic [SEL_W-1:0] light_sel_t;

  localparam light_sel_t SEL_LAST = 6'd59;
  localparam light_sel_t SEL_ZERO = 6'd0;
  localparam light_sel_t SEL_ONE  = 6'd1;

  // Codes above the last valid selector load as zero.
  function automatic light_sel_t sel_clamp(input light_sel_t val, input light_sel_t max_val);
    light_sel_t res;
    if (val <= max_val) begin
      res = val;
    end else begin
      res = SEL_ZERO;
    end
    return res;
  endfunction

endpackage

// File: rtl/light_sel_sequencer_if.sv
// Control/status bundle of the selector sequencer.
// The dir signal exists only when LIGHT_SEQ_DOWN_EN is defined.
interface light_sel_sequencer_if;
  import light_pkg::*;

  logic       en;
  logic       load;
  light_sel_t load_val;
  light_sel_t sel;
  logic       step;
  logic       wrap;
`ifdef LIGHT_SEQ_DOWN_EN
  logic       dir;

  modport master (output en, output load, output load_val, output dir,
                  input sel, input step, input wrap);
  modport slave  (input en, input load, input load_val, input dir,
                  output sel, output step, output wrap);
`else
  modport master (output en, output load, output load_val,
                  input sel, input step, input wrap);
  modport slave  (input en, input load, input load_val,
                  output sel, output step, output wrap);
`endif

endinterface

// File: rtl/light_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV enabled cycles; clr restarts the count.
module light_tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] div_cnt_r;

  // Prescale counter; holds its partial count while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= CNT_ZERO;
    end else if (clr) begin
      div_cnt_r <= CNT_ZERO;
    end else if (en) begin
      if (div_cnt_r == CNT_LAST) begin
        div_cnt_r <= CNT_ZERO;
      end else begin
        div_cnt_r <= div_cnt_r + CNT_ONE;
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  assign tick = en && (div_cnt_r == CNT_LAST);

endmodule

// File: rtl/light_sel_sequencer.sv
// Selector sequencer: advances sel 0..SEL_MAX at a prescaled rate with step/wrap strobes.
// Define LIGHT_SEQ_DOWN_EN to add the dir input and down-counting.
module light_sel_sequencer
  import light_pkg::*;
#(
  parameter int         CLK_DIV = 50000000,
  parameter light_sel_t SEL_MAX = SEL_LAST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  light_sel_sequencer_if.slave  bus
);

  logic       tick_s;
  light_sel_t sel_r;
  light_sel_t next_sel_s;
  logic       next_wrap_s;
  logic       step_r;
  logic       wrap_r;

  light_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (tick_s)
  );

  // Next selector on a tick; an out-of-range code recovers to zero without a wrap.
  always_comb begin
    next_sel_s  = SEL_ZERO;
    next_wrap_s = 1'b0;
`ifdef LIGHT_SEQ_DOWN_EN
    if (bus.dir) begin
      if (sel_r > SEL_MAX) begin
        next_sel_s = SEL_ZERO;
      end else if (sel_r == SEL_ZERO) begin
        next_sel_s  = SEL_MAX;
        next_wrap_s = 1'b1;
      end else begin
        next_sel_s = sel_r - SEL_ONE;
      end
    end else
`endif
    if (sel_r > SEL_MAX) begin
      next_sel_s = SEL_ZERO;
    end else if (sel_r == SEL_MAX) begin
      next_sel_s  = SEL_ZERO;
      next_wrap_s = 1'b1;
    end else begin
      next_sel_s = sel_r + SEL_ONE;
    end
  end

  // Selector and strobes; load beats a coincident tick and emits no strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r  <= SEL_ZERO;
      step_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      sel_r  <= sel_clamp(bus.load_val, SEL_MAX);
      step_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (tick_s) begin
      sel_r  <= next_sel_s;
      step_r <= 1'b1;
      wrap_r <= next_wrap_s;
    end else begin
      sel_r  <= sel_r;
      step_r <= 1'b0;
      wrap_r <= 1'b0;
    end
  end

  assign bus.sel  = sel_r;
  assign bus.step = step_r;
  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_light_sel_sequencer.sv
// Scoreboard bench for light_sel_sequencer with CLK_DIV=4, SEL_MAX=59.
module tb_light_sel_sequencer;
  import light_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int SEL_MX  = 59;

  typedef struct {
    int sel;
    int step;
    int wrap;
  } exp_t;

  logic clk;
  logic rst_n;
  light_sel_sequencer_if bus();

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // reference model state: current selector and enabled cycles since last step/restart
  int m_sel   = 0;
  int m_phase = 0;
  int wraps   = 0;

  light_sel_sequencer #(
    .CLK_DIV (CLK_DIV),
    .SEL_MAX (6'd59)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus; model computes what the outputs must be after the coming edge
  task automatic cyc(input logic e, input logic ld, input int lv, input logic d);
    exp_t x;
    @(negedge clk);
    bus.en       = e;
    bus.load     = ld;
    bus.load_val = lv[5:0];
`ifdef LIGHT_SEQ_DOWN_EN
    bus.dir      = d;
`endif
    x.step = 0;
    x.wrap = 0;
    if (ld) begin
      m_sel   = (lv <= SEL_MX) ? lv : 0;
      m_phase = 0;
    end else if (e) begin
      m_phase++;
      if (m_phase == CLK_DIV) begin
        m_phase = 0;
        x.step  = 1;
`ifdef LIGHT_SEQ_DOWN_EN
        if (d) begin
          x.wrap = (m_sel == 0) ? 1 : 0;
          m_sel  = (m_sel + SEL_MX) % (SEL_MX + 1);
        end else
`endif
        begin
          m_sel  = (m_sel + 1) % (SEL_MX + 1);
          x.wrap = (m_sel == 0) ? 1 : 0;
        end
      end
    end
    x.sel = m_sel;
    exp_q.push_back(x);
  endtask

  // Monitor: each edge, pop the pending expectation and compare
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("sel",  int'(bus.sel),  x.sel);
        chk("step", int'(bus.step), x.step);
        chk("wrap", int'(bus.wrap), x.wrap);
        if (bus.wrap) wraps++;
      end
    end
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 6'd0;
`ifdef LIGHT_SEQ_DOWN_EN
    bus.dir      = 1'b0;
`endif
    #1;
    chk("reset_sel",  int'(bus.sel),  0);
    chk("reset_step", int'(bus.step), 0);
    chk("reset_wrap", int'(bus.wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // first step on the 4th edge, then a full 240-cycle lap with one wrap
    wraps = 0;
    for (int i = 0; i < 240; i++) cyc(1'b1, 1'b0, 0, 1'b0);
    @(posedge clk);
    #2;
    chk("lap_sel", int'(bus.sel), 0);
    chk("lap_wraps", wraps, 1);

    // load in the tick cycle
    n = 0;
    while (m_phase != CLK_DIV - 1 && n < 16) begin
      cyc(1'b1, 1'b0, 0, 1'b0);
      n++;
    end
    chk("tick_align", m_phase, CLK_DIV - 1);
    cyc(1'b1, 1'b1, 45, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b1, 62, 1'b0);
    cyc(1'b0, 1'b1, 17, 1'b0);

    // freeze mid-prescale at count 2
    n = 0;
    while (m_phase != 2 && n < 16) begin
      cyc(1'b1, 1'b0, 0, 1'b0);
      n++;
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 0, 1'b0);

    // randomized mix of enable, loads (incl. out-of-range) and direction
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 30) == 0),
          int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset between edges at sel=30
    cyc(1'b1, 1'b1, 29, 1'b0);
    n = 0;
    while (m_sel != 30 && n < 16) begin
      cyc(1'b1, 1'b0, 0, 1'b0);
      n++;
    end
    chk("reach_30", m_sel, 30);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_sel",  int'(bus.sel),  0);
    chk("async_step", int'(bus.step), 0);
    chk("async_wrap", int'(bus.wrap), 0);
    m_sel   = 0;
    m_phase = 0;
    rst_n   = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 0, 1'b0);

`ifdef LIGHT_SEQ_DOWN_EN
    // down from 1 wraps to SEL_MAX after two ticks
    cyc(1'b1, 1'b1, 1, 1'b1);
    for (int i = 0; i < 2 * CLK_DIV; i++) cyc(1'b1, 1'b0, 0, 1'b1);
    chk("down_sel", m_sel, SEL_MX);
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/light_sel_sequencer.md
# light_sel_sequencer

Selector source for the light-line decoders. Holds the 6-bit `sel` code (0..59) that every line manager decodes into a light state, and advances it at a fixed prescaled rate. It sits between the system clock and the bank of line managers. It also emits one-cycle step and wrap strobes so downstream logic can follow the sequence.

## Interface
Parameters:
- `CLK_DIV`, default 50000000: clock cycles per `sel` step (≥ 2).
- `SEL_MAX`, default 59: last valid selector code (≤ 63).

Ports:
- `clk`, input, 1: system clock; all state on rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `en`, input, 1: run enable. Low freezes both prescaler and `sel`.
- `load`, input, 1: synchronous load strobe.
- `load_val`, input, 6: value written to `sel` on `load`.
- `sel`, output, 6: current selector code, registered.
- `step`, output, 1: one-cycle pulse in the cycle after `sel` advanced.
- `wrap`, output, 1: one-cycle pulse coincident with `step` when `sel` wrapped.
- `dir`, input, 1: direction (0 up, 1 down). Present only with `LIGHT_SEQ_DOWN_EN`.

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 while `en`=1. `tick` = (`div_cnt`==CLK_DIV-1) && `en`. On `tick`, `div_cnt` returns to 0.
- On `tick`, `sel` advances:
  - Up: `sel`==SEL_MAX → 0 and `wrap` set; else `sel`+1.
  - Down (macro only): `sel`==0 → SEL_MAX and `wrap` set; else `sel`-1.
- `load`=1 has priority over `tick` in the same cycle:
  - `sel` ← `load_val` if `load_val` ≤ SEL_MAX, else 0.
  - `div_cnt` ← 0.
  - No `step`/`wrap` pulse.
  - `load` acts regardless of `en`.
- `en`=0: `div_cnt`, `sel` hold; `step`/`wrap` return to 0 next cycle.
- `sel` is never outside 0..SEL_MAX. Any out-of-range state is forced to 0 on the next `tick`.
- No state machine beyond prescaler + selector counter. All arithmetic is unsigned, with widths per `SEL_W` and `$clog2(CLK_DIV)`.

## Timing
- Reset (async, `rst_n`=0): `sel`=0, `div_cnt`=0, `step`=0, `wrap`=0 immediately. First tick occurs CLK_DIV cycles after the first rising edge with `rst_n`=1 and `en`=1.
- `sel` updates on the edge where `tick`=1. `step`/`wrap` are high for exactly the following cycle.
- Step period is exactly CLK_DIV cycles with `en` held high. A full up sequence returns to 0 after (SEL_MAX+1)·CLK_DIV cycles.
- Reset mid-count discards the partial prescale. Deasserting `en` keeps the partial count, which resumes on re-enable.
- `load` in the tick cycle: the loaded value wins and the prescale restarts from 0.

## Configuration
- `LIGHT_SEQ_DOWN_EN` defined: `dir` port exists and down-counting is supported as above. `dir` is sampled on the tick edge only.
- Not defined: no `dir` port; counting is up only.

## Structure
- Shared package `light_pkg` holds:
  - `SEL_W` = 6
  - `SEL_LAST` = 6'd59 (default for `SEL_MAX`)
  - typedef `light_sel_t` = logic [SEL_W-1:0], used by this block and all line managers.
- Sub-module `light_tick_gen`: parameterised prescaler, inputs `clk`/`rst_n`/`en`/`clr`, output `tick`. The selector counter and strobes stay in the top.

## Test plan
Bench uses CLK_DIV=4, SEL_MAX=59.
1. Release reset, `en`=1 → `sel` 0→1 on the 4th edge. `step` pulses for one cycle. `sel` increments every 4 cycles.
2. Run 240 cycles from `sel`=0 → `sel` returns to 0 at cycle 240. `wrap` and `step` are both high for one cycle; `wrap` occurs only there.
3. `load`=1, `load_val`=45 in the same cycle as a tick → `sel`=45 and no `step`. The next advance to 46 comes 4 cycles later. Then `load_val`=62 → `sel`=0.
4. `en`=0 for 10 cycles mid-prescale (`div_cnt`=2) → `sel` is frozen. After re-enable, the advance comes 2 cycles later.
5. `rst_n` pulsed low asynchronously between edges at `sel`=30 → `sel`=0 and strobes=0 immediately, without waiting for a clock edge.
6. With `LIGHT_SEQ_DOWN_EN`, `dir`=1, `sel`=1 → after two ticks `sel`=59 and `wrap` pulses once.
